// File: rtl/iobuf_ctrl_pkg.sv
// iobuf_ctrl_pkg: mode encodings, FSM states and per-mode pin-buffer decode
package iobuf_ctrl_pkg;
   localparam int MODE_W = 2;
   typedef enum logic [MODE_W-1:0] {
      MODE_HIZ       = 2'b00,
      MODE_INPUT     = 2'b01,
      MODE_PUSHPULL  = 2'b10,
      MODE_OPENDRAIN = 2'b11
   } mode_e;
   typedef enum logic {ST_STABLE, ST_BREAK} state_e;
   typedef struct packed {
      logic oe;
      logic od;
      logic dir;
   } drv_t;
   // Driving modes have bit 1 set; those are the ones that turn dir to output
   function automatic drv_t mode_decode(mode_e m);
      return '{oe: m != MODE_HIZ, od: m == MODE_OPENDRAIN, dir: !m[1]};
   endfunction
endpackage

// File: rtl/iobuf_ctrl_if.sv
// iobuf_ctrl_if: mode-request handshake and output data channel
interface iobuf_ctrl_if;
   import iobuf_ctrl_pkg::*;
   logic [MODE_W-1:0] mode_req;
   logic              mode_valid;
   logic              mode_ready;
   logic [MODE_W-1:0] mode_cur;
   logic              out_data;
   modport master(output mode_req, mode_valid, out_data, input mode_ready, mode_cur);
   modport slave(input mode_req, mode_valid, out_data, output mode_ready, mode_cur);
endinterface

// File: rtl/iobuf_infilter.sv
// iobuf_infilter: 2-flop synchronizer, consecutive-sample glitch filter, edge pulses
module iobuf_infilter #(
   parameter int FILT_CYCLES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam int FW = $clog2(FILT_CYCLES) + 1;
   logic          sync1_q, sync1_d, sync2_q, sync2_d;
   logic          level_q, level_d, rise_q, rise_d, fall_q, fall_d;
   logic [FW-1:0] cnt_q, cnt_d;
   logic          flip;
   // Count consecutive mismatching samples; toggle once the run is long enough
   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      flip    = (sync2_q != level_q) && (cnt_q == FW'(FILT_CYCLES - 1));
      cnt_d   = (sync2_q == level_q || flip) ? '0 : cnt_q + FW'(1);
      level_d = level_q ^ flip;
      rise_d  = flip & ~level_q;
      fall_d  = flip & level_q;
   end
   // Synchronizer idles high so an undriven pin reads as released
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end
   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;
endmodule

// File: rtl/iobuf_ctrl.sv
// iobuf_ctrl: pin-mode sequencer with break-before-make dead time and input conditioning
module iobuf_ctrl
   import iobuf_ctrl_pkg::*;
#(
   parameter int DEAD_CYCLES = 4,
   parameter int FILT_CYCLES = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   iobuf_ctrl_if.slave  bus,
   output logic         pin_level,
   output logic         pin_rise,
   output logic         pin_fall,
   output logic         io_oe,
   output logic         io_od,
   output logic         io_dir,
   output logic         io_din,
   input  logic         io_dout
);
   localparam int DW = $clog2(DEAD_CYCLES) + 1;
   state_e        state_q, state_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   mode_e         pend_q, pend_d, mode_q, mode_d, req;
   drv_t          drv_q, drv_d;
   logic          din_q, din_d;
   assign req = mode_e'(bus.mode_req);
   // Leaving a driving mode parks the pin in Hi-Z for the dead time before the new mode
   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      pend_d  = pend_q;
      mode_d  = mode_q;
      drv_d   = drv_q;
      din_d   = bus.out_data;
      if (state_q == ST_STABLE) begin
         if (bus.mode_valid && req != mode_q) begin
            if (mode_q[1]) begin
               state_d = ST_BREAK;
               dcnt_d  = DW'(DEAD_CYCLES);
               pend_d  = req;
               mode_d  = MODE_HIZ;
               drv_d   = mode_decode(MODE_HIZ);
            end else begin
               mode_d = req;
               drv_d  = mode_decode(req);
            end
         end
      end else begin
         dcnt_d = dcnt_q - DW'(1);
         if (dcnt_q == DW'(1)) begin
            state_d = ST_STABLE;
            mode_d  = pend_q;
            drv_d   = mode_decode(pend_q);
         end
      end
   end
   // Reset drops any pending mode and returns the pin to Hi-Z at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_STABLE;
         dcnt_q  <= '0;
         pend_q  <= MODE_HIZ;
         mode_q  <= MODE_HIZ;
         drv_q   <= mode_decode(MODE_HIZ);
         din_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         pend_q  <= pend_d;
         mode_q  <= mode_d;
         drv_q   <= drv_d;
         din_q   <= din_d;
      end
   end
   assign bus.mode_ready = (state_q == ST_STABLE);
   assign bus.mode_cur   = mode_q;
   assign io_oe          = drv_q.oe;
   assign io_od          = drv_q.od;
   assign io_dir         = drv_q.dir;
   assign io_din         = din_q;
   iobuf_infilter #(.FILT_CYCLES(FILT_CYCLES)) u_infilter (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (io_dout),
      .level(pin_level),
      .rise (pin_rise),
      .fall (pin_fall)
   );
endmodule

// File: tb/tb_iobuf_ctrl.sv
// tb_iobuf_ctrl: directed checks of handshake, dead time, input filter and reset abort
module tb_iobuf_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic io_dout = 1'b1;
   logic pin_level, pin_rise, pin_fall, io_oe, io_od, io_dir, io_din;
   int   n_tests = 0;
   int   n_fail = 0;
   iobuf_ctrl_if bus();
   iobuf_ctrl #(.DEAD_CYCLES(4), .FILT_CYCLES(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .pin_level(pin_level),
      .pin_rise (pin_rise),
      .pin_fall (pin_fall),
      .io_oe    (io_oe),
      .io_od    (io_od),
      .io_dir   (io_dir),
      .io_din   (io_din),
      .io_dout  (io_dout)
   );
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, " oe"}, io_oe, 0);
      check({tag, " od"}, io_od, 0);
      check({tag, " dir"}, io_dir, 1);
      check({tag, " din"}, io_din, 0);
      check({tag, " mode_cur"}, bus.mode_cur, 0);
      check({tag, " ready"}, bus.mode_ready, 1);
      check({tag, " level"}, pin_level, 1);
      check({tag, " rise"}, pin_rise, 0);
      check({tag, " fall"}, pin_fall, 0);
   endtask

   initial begin
      int falls, rises, lows, at, ready_low, oe_low, in_seen;
      bus.mode_req = 2'b00;
      bus.mode_valid = 1'b0;
      bus.out_data = 1'b0;
      tick(2);
      check_idle("in_reset");
      rst_n = 1'b1;
      tick(4);
      check_idle("after_reset");

      // HIZ -> PUSHPULL, no dead time
      bus.mode_req = 2'b10; bus.mode_valid = 1'b1; bus.out_data = 1'b1;
      tick(1);
      bus.mode_valid = 1'b0;
      check("pp oe", io_oe, 1);
      check("pp dir", io_dir, 0);
      check("pp od", io_od, 0);
      check("pp din", io_din, 1);
      check("pp mode_cur", bus.mode_cur, 2);
      check("pp ready", bus.mode_ready, 1);

      // PUSHPULL -> OPENDRAIN with a competing request held during BREAK
      bus.mode_req = 2'b11; bus.mode_valid = 1'b1;
      tick(1);
      bus.mode_req = 2'b01;
      oe_low = 0; ready_low = 0;
      for (int i = 1; i <= 4; i++) begin
         if (io_oe == 1'b0) oe_low++;
         if (bus.mode_ready == 1'b0) ready_low++;
         check($sformatf("brk%0d mode_cur", i), bus.mode_cur, 0);
         if (i == 4) bus.mode_valid = 1'b0;
         else tick(1);
      end
      check("brk oe_low_cycles", oe_low, 4);
      check("brk ready_low_cycles", ready_low, 4);
      tick(1);
      check("od oe", io_oe, 1);
      check("od od", io_od, 1);
      check("od dir", io_dir, 0);
      check("od mode_cur", bus.mode_cur, 3);
      check("od ready", bus.mode_ready, 1);
      bus.out_data = 1'b0;
      tick(1);
      check("din latency", io_din, 0);
      check("od held", bus.mode_cur, 3);

      // Stable 1->0 on the pin
      io_dout = 1'b0;
      falls = 0; at = 0;
      for (int i = 1; i <= 10; i++) begin
         tick(1);
         if (pin_fall) begin falls++; at = i; end
      end
      check("fall pulses", falls, 1);
      check("fall latency", at, 5);
      check("level low", pin_level, 0);
      io_dout = 1'b1;
      rises = 0; at = 0;
      for (int i = 1; i <= 10; i++) begin
         tick(1);
         if (pin_rise) begin rises++; at = i; end
      end
      check("rise pulses", rises, 1);
      check("rise latency", at, 5);
      check("level high", pin_level, 1);

      // Two 2-cycle glitches must be swallowed
      falls = 0; lows = 0;
      for (int g = 0; g < 2; g++) begin
         io_dout = 1'b0;
         tick(2);
         io_dout = 1'b1;
         for (int i = 0; i < 8; i++) begin
            tick(1);
            if (pin_fall) falls++;
            if (!pin_level) lows++;
         end
      end
      check("glitch falls", falls, 0);
      check("glitch lows", lows, 0);

      // Back to PUSHPULL, then abort PUSHPULL->INPUT by reset in the second BREAK cycle
      bus.mode_req = 2'b10; bus.mode_valid = 1'b1;
      tick(1);
      bus.mode_valid = 1'b0;
      tick(4);
      check("pp2 mode_cur", bus.mode_cur, 2);
      check("pp2 oe", io_oe, 1);
      bus.mode_req = 2'b01; bus.mode_valid = 1'b1;
      tick(1);
      bus.mode_valid = 1'b0;
      tick(1);
      check("abort pre ready", bus.mode_ready, 0);
      rst_n = 1'b0;
      #1;
      check("abort oe", io_oe, 0);
      check("abort mode_cur", bus.mode_cur, 0);
      check("abort dir", io_dir, 1);
      check("abort ready", bus.mode_ready, 1);
      tick(2);
      rst_n = 1'b1;
      in_seen = 0; oe_low = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (bus.mode_cur == 2'b01) in_seen++;
         if (io_oe == 1'b0) oe_low++;
      end
      check("abort input applied", in_seen, 0);
      check("abort oe low cycles", oe_low, 8);
      check("abort ready after", bus.mode_ready, 1);
      check("abort mode_cur after", bus.mode_cur, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
